// File: rtl/imem_boot_loader.sv
// Serial boot loader: receives a length-prefixed, XOR-checksummed byte frame,
// writes each assembled big-endian word into instruction memory and holds the core in reset until verified.
module imem_boot_loader #(
  parameter int          ADDR_W     = 8,
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        load_req,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } loadState_t;

  localparam logic [16:0] MAX_WORDS = 17'(IMEM_WORDS);

  loadState_t        state;
  logic [7:0]        lenHi;
  logic [15:0]       lenWords;
  logic [ADDR_W-1:0] wordIndex;
  logic [15:0]       wordsAssembled;
  logic [1:0]        byteCount;
  logic [23:0]       partialWord;
  logic [7:0]        csumAcc;

  logic              rxFire;
  logic [15:0]       lenNext;
  logic [15:0]       wordsNext;

  // NOTE: rx_ready decodes the state register directly so a byte offered in
  // the cycle the loader enters a terminal state is never accepted.
  assign rx_ready  = (state != S_DONE) && (state != S_ERR);
  assign rxFire    = rx_valid && rx_ready;
  assign lenNext   = {lenHi, rx_data};
  assign wordsNext = wordsAssembled + 16'd1;

  // NOTE: every register here is state, so it is updated with non-blocking
  // assignments only and cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_LEN_HI;
      lenHi          <= '0;
      lenWords       <= '0;
      wordIndex      <= '0;
      wordsAssembled <= '0;
      byteCount      <= '0;
      partialWord    <= '0;
      csumAcc        <= '0;
      imem_we        <= 1'b0;
      imem_addr      <= BASE_ADDR;
      imem_wdata     <= '0;
      cpu_reset      <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
      words_loaded   <= '0;
    end else begin
      // Write strobe is a single-cycle pulse unless another word completes.
      imem_we <= 1'b0;

      if (imem_we && (words_loaded != lenWords)) begin
        words_loaded <= words_loaded + 16'd1;
      end

      if (load_req) begin
        // Restart wins over any coincident byte; a partial word is discarded.
        state          <= S_LEN_HI;
        wordIndex      <= '0;
        wordsAssembled <= '0;
        byteCount      <= '0;
        partialWord    <= '0;
        csumAcc        <= '0;
        words_loaded   <= '0;
        cpu_reset      <= 1'b1;
        done           <= 1'b0;
        error          <= 1'b0;
      end else if (rxFire) begin
        unique case (state)
          S_LEN_HI: begin
            lenHi   <= rx_data;
            csumAcc <= csumAcc ^ rx_data;
            state   <= S_LEN_LO;
          end

          S_LEN_LO: begin
            lenWords <= lenNext;
            csumAcc  <= csumAcc ^ rx_data;
            if ({1'b0, lenNext} > MAX_WORDS) begin
              state <= S_ERR;
              error <= 1'b1;
            end else if (lenNext == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end

          S_DATA: begin
            csumAcc     <= csumAcc ^ rx_data;
            partialWord <= {partialWord[15:0], rx_data};
            byteCount   <= byteCount + 2'd1;
            if (byteCount == 2'd3) begin
              imem_we        <= 1'b1;
              imem_addr      <= BASE_ADDR + 32'({wordIndex, 2'b00});
              imem_wdata     <= {partialWord, rx_data};
              wordIndex      <= wordIndex + ADDR_W'(1);
              wordsAssembled <= wordsNext;
              if (wordsNext == lenWords) begin
                state <= S_CSUM;
              end
            end
          end

          S_CSUM: begin
            if (rx_data == csumAcc) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end

          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: two instances (base 0 and 0x400) share one byte stream;
// expected writes are queued from a frame-level model and popped by per-instance monitors.
module tb_imem_boot_loader;

  localparam int          ADDR_W     = 8;
  localparam int          IMEM_WORDS = 256;
  localparam logic [31:0] BASE0      = 32'h0000_0000;
  localparam logic [31:0] BASE1      = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        load_req;

  logic        rxReady0, imemWe0, cpuReset0, done0, error0;
  logic [31:0] imemAddr0, imemWdata0;
  logic [15:0] wordsLoaded0;
  logic        rxReady1, imemWe1, cpuReset1, done1, error1;
  logic [31:0] imemAddr1, imemWdata1;
  logic [15:0] wordsLoaded1;

  imem_boot_loader #(.ADDR_W(ADDR_W), .IMEM_WORDS(IMEM_WORDS), .BASE_ADDR(BASE0)) dut0 (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rxReady0),
    .load_req(load_req), .imem_we(imemWe0), .imem_addr(imemAddr0), .imem_wdata(imemWdata0),
    .cpu_reset(cpuReset0), .done(done0), .error(error0), .words_loaded(wordsLoaded0)
  );

  imem_boot_loader #(.ADDR_W(ADDR_W), .IMEM_WORDS(IMEM_WORDS), .BASE_ADDR(BASE1)) dut1 (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rxReady1),
    .load_req(load_req), .imem_we(imemWe1), .imem_addr(imemAddr1), .imem_wdata(imemWdata1),
    .cpu_reset(cpuReset1), .done(done1), .error(error1), .words_loaded(wordsLoaded1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } expWrite_t;

  expWrite_t   exp0[$];
  expWrite_t   exp1[$];
  logic [31:0] frameWords[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, req);
    end
  endtask

  // Monitor side: pop the oldest expected write whenever a DUT strobes imem_we.
  task automatic checkWrite(input int which, input logic [31:0] addr, input logic [31:0] data,
                            input logic [15:0] wl);
    expWrite_t   e;
    logic [31:0] base;
    int          depth;
    depth = (which == 0) ? exp0.size() : exp1.size();
    if (depth == 0) begin
      check($sformatf("dut%0d_unexpected_write_qdepth", which), 32'(depth), 32'd1);
    end else begin
      if (which == 0) e = exp0.pop_front();
      else            e = exp1.pop_front();
      base = (which == 0) ? BASE0 : BASE1;
      check($sformatf("dut%0d_write%0d_addr", which, e.idx), addr, base + 32'(4 * e.idx));
      check($sformatf("dut%0d_write%0d_data", which, e.idx), data, e.data);
      check($sformatf("dut%0d_write%0d_words_loaded", which, e.idx), 32'(wl), 32'(e.idx));
    end
  endtask

  always @(negedge clk) begin
    if (!reset && imemWe0) checkWrite(0, imemAddr0, imemWdata0, wordsLoaded0);
  end

  always @(negedge clk) begin
    if (!reset && imemWe1) checkWrite(1, imemAddr1, imemWdata1, wordsLoaded1);
  end

  task automatic checkStatus(input string name, input bit expDone, input bit expErr, input int expWl);
    check({name, "_done0"},      32'(done0),        32'(expDone));
    check({name, "_done1"},      32'(done1),        32'(expDone));
    check({name, "_error0"},     32'(error0),       32'(expErr));
    check({name, "_error1"},     32'(error1),       32'(expErr));
    check({name, "_cpu_reset0"}, 32'(cpuReset0),    32'(!expDone));
    check({name, "_cpu_reset1"}, 32'(cpuReset1),    32'(!expDone));
    check({name, "_rx_ready0"},  32'(rxReady0),     32'(!(expDone || expErr)));
    check({name, "_rx_ready1"},  32'(rxReady1),     32'(!(expDone || expErr)));
    check({name, "_words0"},     32'(wordsLoaded0), 32'(expWl));
    check({name, "_words1"},     32'(wordsLoaded1), 32'(expWl));
    check({name, "_pending0"},   32'(exp0.size()),  32'd0);
    check({name, "_pending1"},   32'(exp1.size()),  32'd0);
  endtask

  // Offer one byte after 0..gapMax idle cycles; returns at the negedge before its transfer edge.
  task automatic sendByte(input logic [7:0] b, input int gapMax);
    int gaps;
    int waitCycles;
    gaps = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
    repeat (gaps) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    waitCycles = 0;
    while (!rxReady0 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!rxReady0) check("rx_ready_timeout", 32'(rxReady0), 32'd1);
  endtask

  task automatic pushExpected(input int idx, input logic [31:0] w);
    expWrite_t e;
    e.idx  = idx;
    e.data = w;
    exp0.push_back(e);
    exp1.push_back(e);
  endtask

  task automatic startLoad(input string name);
    @(negedge clk);
    rx_valid = 1'b0;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    checkStatus(name, 1'b0, 1'b0, 0);
  endtask

  // Frame-level model: build the byte stream from frameWords, predict writes and final status.
  task automatic runFrame(input string name, input int n, input bit badCsum, input int gapMax);
    logic [7:0]  frameBytes[$];
    logic [7:0]  x;
    logic [15:0] len;
    logic [31:0] w;
    bit          oversize;
    bit          expDone;
    len      = 16'(n);
    oversize = (n > IMEM_WORDS);
    x        = 8'h00;
    frameBytes.push_back(len[15:8]);
    frameBytes.push_back(len[7:0]);
    if (!oversize) begin
      for (int i = 0; i < n; i++) begin
        w = frameWords[i];
        for (int k = 3; k >= 0; k--) frameBytes.push_back(w[8*k +: 8]);
        pushExpected(i, w);
      end
      foreach (frameBytes[j]) x = x ^ frameBytes[j];
      frameBytes.push_back(badCsum ? (x ^ 8'h01) : x);
    end
    foreach (frameBytes[j]) sendByte(frameBytes[j], gapMax);
    @(negedge clk);
    rx_valid = 1'b0;
    expDone = !oversize && !badCsum;
    checkStatus(name, expDone, !expDone, oversize ? 0 : n);
    repeat (3) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    checkStatus({name, "_hold"}, expDone, !expDone, oversize ? 0 : n);
  endtask

  task automatic randomWords(input int n);
    frameWords.delete();
    for (int i = 0; i < n; i++) frameWords.push_back($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    load_req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_we0",    32'(imemWe0),    32'd0);
    check("rst_we1",    32'(imemWe1),    32'd0);
    check("rst_addr0",  imemAddr0,       BASE0);
    check("rst_addr1",  imemAddr1,       BASE1);
    check("rst_wdata0", imemWdata0,      32'd0);
    check("rst_wdata1", imemWdata1,      32'd0);
    checkStatus("rst", 1'b0, 1'b0, 0);

    frameWords = '{32'h1234_5678, 32'h9ABC_DEF0};
    runFrame("normal", 2, 1'b0, 0);

    startLoad("load_zero");
    runFrame("zero_len", 0, 1'b0, 0);

    startLoad("load_over");
    runFrame("oversize_257", 257, 1'b0, 0);

    startLoad("load_bad");
    frameWords = '{32'h1234_5678, 32'h9ABC_DEF0};
    runFrame("bad_csum", 2, 1'b1, 0);

    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(8, 1));
      randomWords(n);
      startLoad($sformatf("load_thr%0d", r));
      runFrame($sformatf("throttled%0d", r), n, 1'b0, 3);
    end

    startLoad("load_max");
    randomWords(IMEM_WORDS);
    runFrame("max_len", IMEM_WORDS, 1'b0, 0);

    startLoad("load_ffff");
    runFrame("oversize_ffff", 65535, 1'b0, 0);

    // Restart mid-word with a coincident byte that must be dropped.
    startLoad("load_restart");
    sendByte(8'h00, 0);
    sendByte(8'h02, 0);
    sendByte(8'h11, 0);
    sendByte(8'h22, 0);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    rx_valid = 1'b0;
    checkStatus("restart_mid_word", 1'b0, 1'b0, 0);
    frameWords = '{32'hCAFE_F00D, 32'h0BAD_BEEF};
    runFrame("after_restart", 2, 1'b0, 1);

    // Reset while a write strobe is high.
    startLoad("load_reset");
    frameWords = '{32'hA5A5_5A5A, 32'h0102_0304};
    pushExpected(0, frameWords[0]);
    sendByte(8'h00, 0);
    sendByte(8'h02, 0);
    for (int k = 3; k >= 0; k--) sendByte(frameWords[0][8*k +: 8], 0);
    @(negedge clk);
    rx_valid = 1'b0;
    check("we_before_reset", 32'(imemWe0), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_we0",    32'(imemWe0),    32'd0);
    check("async_rst_we1",    32'(imemWe1),    32'd0);
    check("async_rst_addr0",  imemAddr0,       BASE0);
    check("async_rst_addr1",  imemAddr1,       BASE1);
    check("async_rst_wdata0", imemWdata0,      32'd0);
    checkStatus("async_rst", 1'b0, 1'b0, 0);
    @(negedge clk);
    reset = 1'b0;
    randomWords(3);
    runFrame("after_reset", 3, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
